// File: rtl/aska_stim_monitor.sv
// Receive-side checker for the stimulator output bus: decodes biphasic pulses,
// measures phase/gap/period/charge and keeps sticky safety faults.
module aska_stim_monitor #(
  parameter int unsigned ELEC_W      = 32,
  parameter int unsigned DAC_W       = 6,
  parameter int unsigned PER_W       = 12,
  parameter int unsigned GAP_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [ELEC_W-1:0] up_switches,
  input  logic [ELEC_W-1:0] down_switches,
  input  logic [DAC_W-1:0]  dac,
  input  logic [DAC_W-1:0]  amp_limit,
  input  logic [2:0]        phase_limit,
  input  logic              fault_clear,
  output logic [3:0]        phase_up_len,
  output logic [3:0]        phase_down_len,
  output logic [3:0]        gap_len,
  output logic [9:0]        charge_up,
  output logic [9:0]        charge_down,
  output logic [PER_W-1:0]  period,
  output logic              period_valid,
  output logic              meas_valid,
  output logic              fault_overlap,
  output logic              fault_amp,
  output logic              fault_phase,
  output logic              fault_pattern,
  output logic              fault_balance,
  output logic              fault_any
);

  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CHG_W   = 10;
  localparam int unsigned SUM_W   = CHG_W + 1;
  localparam int unsigned FAULT_W = 5;

  localparam int unsigned F_OVERLAP = 0;
  localparam int unsigned F_AMP     = 1;
  localparam int unsigned F_PHASE   = 2;
  localparam int unsigned F_PATTERN = 3;
  localparam int unsigned F_BALANCE = 4;

  localparam logic [LEN_W-1:0] LEN_MAX   = '1;
  localparam logic [CHG_W-1:0] CHG_MAX   = '1;
  localparam logic [PER_W-1:0] PER_MAX   = '1;
  localparam logic [LEN_W-1:0] GAP_LIMIT = LEN_W'(GAP_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP_PH = 2'd1,
    GAP   = 2'd2,
    DN_PH = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ELEC_W-1:0]  a_q, a_d;
  logic [ELEC_W-1:0]  b_q, b_d;
  logic [LEN_W-1:0]   len_up_q, len_up_d;
  logic [LEN_W-1:0]   len_dn_q, len_dn_d;
  logic [LEN_W-1:0]   gap_q, gap_d;
  logic [CHG_W-1:0]   chg_up_q, chg_up_d;
  logic [CHG_W-1:0]   chg_dn_q, chg_dn_d;
  logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
  logic               seen_start_q, seen_start_d;
  logic [FAULT_W-1:0] fault_q, fault_d;
  logic [FAULT_W-1:0] fault_set;

  logic [3:0]       phase_up_len_d, phase_down_len_d, gap_len_d;
  logic [9:0]       charge_up_d, charge_down_d;
  logic [PER_W-1:0] period_d;
  logic             period_valid_d, meas_valid_d;

  logic             bus_up, bus_zero, bus_fwd, bus_rev;
  logic             anodic_start;
  logic [LEN_W-1:0] gap_inc;
  logic [PER_W-1:0] per_inc;

  // Saturating +1 for the 4-bit length/gap counters.
  function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] v);
    return (v == LEN_MAX) ? v : v + LEN_W'(1);
  endfunction

  // Saturating charge accumulation.
  function automatic logic [CHG_W-1:0] chg_add(input logic [CHG_W-1:0] acc,
                                               input logic [DAC_W-1:0] d);
    logic [SUM_W-1:0] s;
    s = SUM_W'(acc) + SUM_W'(d);
    return s[CHG_W] ? CHG_MAX : s[CHG_W-1:0];
  endfunction

  // Classify the bus relative to the pattern latched at anodic start.
  always_comb begin
    bus_up   = |up_switches;
    bus_zero = ~bus_up && ~(|down_switches);
    bus_fwd  = (up_switches == a_q) && (down_switches == b_q);
    bus_rev  = (up_switches == b_q) && (down_switches == a_q);
    gap_inc  = len_inc(gap_q);
    per_inc  = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + PER_W'(1);
  end

  // Next-state, measurement and fault logic.
  always_comb begin
    state_d          = state_q;
    a_d              = a_q;
    b_d              = b_q;
    len_up_d         = len_up_q;
    len_dn_d         = len_dn_q;
    gap_d            = gap_q;
    chg_up_d         = chg_up_q;
    chg_dn_d         = chg_dn_q;
    per_cnt_d        = per_inc;
    seen_start_d     = seen_start_q;
    phase_up_len_d   = phase_up_len;
    phase_down_len_d = phase_down_len;
    gap_len_d        = gap_len;
    charge_up_d      = charge_up;
    charge_down_d    = charge_down;
    period_d         = period;
    period_valid_d   = period_valid;
    meas_valid_d     = 1'b0;
    fault_set        = '0;
    anodic_start     = 1'b0;

    if (!enable) begin
      state_d        = IDLE;
      len_up_d       = '0;
      len_dn_d       = '0;
      gap_d          = '0;
      chg_up_d       = '0;
      chg_dn_d       = '0;
      per_cnt_d      = '0;
      seen_start_d   = 1'b0;
      period_valid_d = 1'b0;
    end else begin
      fault_set[F_OVERLAP] = |(up_switches & down_switches);
      fault_set[F_AMP]     = bus_up && (dac > amp_limit);

      unique case (state_q)
        IDLE: begin
          if (bus_up) begin
            a_d          = up_switches;
            b_d          = down_switches;
            len_up_d     = LEN_W'(1);
            chg_up_d     = CHG_W'(dac);
            anodic_start = 1'b1;
            state_d      = UP_PH;
          end
        end
        UP_PH: begin
          if (bus_fwd) begin
            len_up_d = len_inc(len_up_q);
            chg_up_d = chg_add(chg_up_q, dac);
          end else if (bus_zero) begin
            gap_d = LEN_W'(1);
            if (LEN_W'(1) >= GAP_LIMIT) begin
              fault_set[F_BALANCE] = 1'b1;
              state_d              = IDLE;
            end else begin
              state_d = GAP;
            end
          end else if (bus_rev) begin
            gap_d    = '0;
            len_dn_d = LEN_W'(1);
            chg_dn_d = CHG_W'(dac);
            state_d  = DN_PH;
          end else begin
            fault_set[F_PATTERN] = 1'b1;
            state_d              = IDLE;
          end
        end
        GAP: begin
          if (bus_zero) begin
            gap_d = gap_inc;
            if (gap_inc >= GAP_LIMIT) begin
              fault_set[F_BALANCE] = 1'b1;
              state_d              = IDLE;
            end
          end else if (bus_rev) begin
            len_dn_d = LEN_W'(1);
            chg_dn_d = CHG_W'(dac);
            state_d  = DN_PH;
          end else begin
            fault_set[F_PATTERN] = 1'b1;
            state_d              = IDLE;
          end
        end
        DN_PH: begin
          if (bus_rev) begin
            len_dn_d = len_inc(len_dn_q);
            chg_dn_d = chg_add(chg_dn_q, dac);
          end else if (bus_zero) begin
            phase_up_len_d       = len_up_q;
            phase_down_len_d     = len_dn_q;
            gap_len_d            = gap_q;
            charge_up_d          = chg_up_q;
            charge_down_d        = chg_dn_q;
            meas_valid_d         = 1'b1;
            fault_set[F_BALANCE] = (len_up_q != len_dn_q) || (chg_up_q != chg_dn_q);
            fault_set[F_PHASE]   = (len_up_q > {1'b0, phase_limit}) ||
                                   (len_dn_q > {1'b0, phase_limit});
            state_d              = IDLE;
          end else begin
            fault_set[F_PATTERN] = 1'b1;
            state_d              = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (anodic_start) begin
        per_cnt_d    = '0;
        seen_start_d = 1'b1;
        if (seen_start_q) begin
          period_d       = per_inc;
          period_valid_d = 1'b1;
        end
      end
    end

    fault_d = (fault_q & ~{FAULT_W{fault_clear}}) | fault_set;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      len_up_q       <= '0;
      len_dn_q       <= '0;
      gap_q          <= '0;
      chg_up_q       <= '0;
      chg_dn_q       <= '0;
      per_cnt_q      <= '0;
      seen_start_q   <= 1'b0;
      fault_q        <= '0;
      phase_up_len   <= '0;
      phase_down_len <= '0;
      gap_len        <= '0;
      charge_up      <= '0;
      charge_down    <= '0;
      period         <= '0;
      period_valid   <= 1'b0;
      meas_valid     <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      len_up_q       <= len_up_d;
      len_dn_q       <= len_dn_d;
      gap_q          <= gap_d;
      chg_up_q       <= chg_up_d;
      chg_dn_q       <= chg_dn_d;
      per_cnt_q      <= per_cnt_d;
      seen_start_q   <= seen_start_d;
      fault_q        <= fault_d;
      phase_up_len   <= phase_up_len_d;
      phase_down_len <= phase_down_len_d;
      gap_len        <= gap_len_d;
      charge_up      <= charge_up_d;
      charge_down    <= charge_down_d;
      period         <= period_d;
      period_valid   <= period_valid_d;
      meas_valid     <= meas_valid_d;
    end
  end

  // Sticky fault outputs and their summary.
  assign fault_overlap = fault_q[F_OVERLAP];
  assign fault_amp     = fault_q[F_AMP];
  assign fault_phase   = fault_q[F_PHASE];
  assign fault_pattern = fault_q[F_PATTERN];
  assign fault_balance = fault_q[F_BALANCE];
  assign fault_any     = |fault_q;

endmodule
